// File: rtl/imem_fetch_pkg.sv
// Shared types for the LC3 instruction-fetch sequencer and its prefetch buffer.
// Optional watchdog build switch used by the top level: FETCH_TIMEOUT_EN.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ibuf_entry_t;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;

endpackage

// File: rtl/imem_fetch_fifo.sv
// DEPTH-entry prefetch FIFO of {pc, instr} entries with synchronous flush.
// Head entry is presented straight from storage; pop on an empty FIFO is ignored.
module imem_fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  ibuf_entry_t   push_data,
    input  logic          pop,
    input  logic          flush,
    output ibuf_entry_t   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    ibuf_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && !empty;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !do_pop)      count <= count + CW'(1);
            else if (!push && do_pop) count <= count - CW'(1);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// LC3 instruction-fetch sequencer: drives pc/instrmem_rd, fills the prefetch buffer.
// Define FETCH_TIMEOUT_EN to add the fetch watchdog and its sticky fetch_timeout port.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int          DEPTH          = 2,
    parameter logic [15:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         redirect_valid,
    input  logic [15:0]  redirect_pc,
    output logic [15:0]  pc,
    output logic         instrmem_rd,
    input  logic [15:0]  instr_dout,
    input  logic         complete_instr,
    output logic         ibuf_valid,
    output logic [15:0]  ibuf_instr,
    output logic [15:0]  ibuf_pc,
    input  logic         ibuf_ready,
    output logic         busy,
`ifdef FETCH_TIMEOUT_EN
    output logic         fetch_timeout,
`endif
    output fetch_state_e fsm_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("imem_fetch_ctrl: DEPTH must be a power of two in 2..8, TIMEOUT_CYCLES >= 1");
    end

    fetch_state_e  state;
    logic [15:0]   redirect_hold;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    ibuf_entry_t   head;
    logic          pop;
    logic          push;
    logic [CW:0]   occ_after_pop;
    logic          space_now;
    logic          space_after_push;
    logic          timeout_hit;

    // Handshakes: an ibuf entry transfers on a cycle with ibuf_valid && ibuf_ready;
    // an imem request holds instrmem_rd and pc steady until the one-cycle complete_instr.
    assign pop              = !empty && ibuf_ready;
    assign push             = (state == FETCH) && complete_instr && !redirect_valid;
    assign occ_after_pop    = {1'b0, count} - {{CW{1'b0}}, pop};
    assign space_now        = occ_after_pop < (CW+1)'(DEPTH);
    assign space_after_push = (occ_after_pop + (CW+1)'(1)) < (CW+1)'(DEPTH);

    imem_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: pc, instr: instr_dout}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;

    assign timeout_hit = busy && !complete_instr && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt        <= '0;
            fetch_timeout <= 1'b0;
        end else begin
            if (timeout_hit) fetch_timeout <= 1'b1;
            if (!busy || complete_instr || timeout_hit) wd_cnt <= '0;
            else                                        wd_cnt <= wd_cnt + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            redirect_hold <= '0;
            instrmem_rd   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (enable && space_now) begin
                        state       <= FETCH;
                        instrmem_rd <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    if (complete_instr) begin
                        if (redirect_valid) begin
                            pc          <= redirect_pc;
                            state       <= IDLE;
                            instrmem_rd <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            pc <= pc + 16'd1;
                            if (!(enable && space_after_push)) begin
                                state       <= IDLE;
                                instrmem_rd <= 1'b0;
                                busy        <= 1'b0;
                            end
                        end
                    end else if (timeout_hit) begin
                        if (redirect_valid) pc <= redirect_pc;
                        state       <= IDLE;
                        instrmem_rd <= 1'b0;
                        busy        <= 1'b0;
                    end else if (redirect_valid) begin
                        state         <= DRAIN;
                        redirect_hold <= redirect_pc;
                    end
                end
                DRAIN: begin
                    // The in-flight response is dropped; only the newest redirect target survives.
                    if (complete_instr || timeout_hit) begin
                        pc          <= redirect_valid ? redirect_pc : redirect_hold;
                        state       <= IDLE;
                        instrmem_rd <= 1'b0;
                        busy        <= 1'b0;
                    end else if (redirect_valid) begin
                        redirect_hold <= redirect_pc;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instrmem_rd <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign ibuf_valid = !empty;
    assign ibuf_instr = head.instr;
    assign ibuf_pc    = head.pc;
    assign fsm_state  = state;

    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
        (complete_instr && state == FETCH) |-> (!full || pop));
`ifndef FETCH_TIMEOUT_EN
    a_complete_needs_request: assert property (@(posedge clock) disable iff (reset)
        complete_instr |-> instrmem_rd);
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic against a queue-based fetch model.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
    import imem_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [15:0]  redirect_pc = '0;
    logic [15:0]  pc;
    logic         instrmem_rd;
    logic [15:0]  instr_dout = '0;
    logic         complete_instr = 1'b0;
    logic         ibuf_valid;
    logic [15:0]  ibuf_instr;
    logic [15:0]  ibuf_pc;
    logic         ibuf_ready = 1'b0;
    logic         busy;
    fetch_state_e fsm_state;
`ifdef FETCH_TIMEOUT_EN
    logic         fetch_timeout;
`endif

    imem_fetch_ctrl #(
        .DEPTH          (DEPTH),
        .RESET_PC       (16'h3000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .instr_dout     (instr_dout),
        .complete_instr (complete_instr),
        .ibuf_valid     (ibuf_valid),
        .ibuf_instr     (ibuf_instr),
        .ibuf_pc        (ibuf_pc),
        .ibuf_ready     (ibuf_ready),
        .busy           (busy),
`ifdef FETCH_TIMEOUT_EN
        .fetch_timeout  (fetch_timeout),
`endif
        .fsm_state      (fsm_state)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard / reference model: buffered {pc, instr} entries and the fetch stream position.
    logic [31:0] exp_q[$];
    logic        m_out;
    logic        m_discard;
    logic [15:0] m_pc;
    logic [15:0] m_target;
    bit          model_on = 1'b1;

    // Memory responder.
    bit mem_active = 1'b0;
    int mem_left   = 0;
    int lat_fixed  = 1;
    int n_cpl      = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a + 16'h1000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        fetch_state_e exp_state;
        if (!model_on) return;
        exp_state = !m_out ? IDLE : (m_discard ? DRAIN : FETCH);
        chk("state", fsm_state, exp_state);
        chk("instrmem_rd", instrmem_rd, m_out);
        chk("busy", busy, m_out);
        chk("pc", pc, m_pc);
        chk("ibuf_valid", ibuf_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("ibuf_pc", ibuf_pc, exp_q[0][31:16]);
            chk("ibuf_instr", ibuf_instr, exp_q[0][15:0]);
        end
`ifdef FETCH_TIMEOUT_EN
        chk("fetch_timeout_quiet", fetch_timeout, 0);
`endif
    endtask

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_update();
        bit popped;
        popped = (exp_q.size() > 0) && ibuf_ready;
        if (m_out && complete_instr) begin
            if (redirect_valid) begin
                exp_q.delete();
                m_pc      = redirect_pc;
                m_out     = 1'b0;
                m_discard = 1'b0;
            end else if (m_discard) begin
                if (popped) void'(exp_q.pop_front());
                m_pc      = m_target;
                m_out     = 1'b0;
                m_discard = 1'b0;
            end else begin
                if (popped) void'(exp_q.pop_front());
                exp_q.push_back({m_pc, mem_word(m_pc)});
                m_pc  = m_pc + 16'd1;
                m_out = enable && (exp_q.size() < DEPTH);
            end
        end else if (redirect_valid) begin
            exp_q.delete();
            if (m_out) begin
                m_discard = 1'b1;
                m_target  = redirect_pc;
            end else begin
                m_pc = redirect_pc;
            end
        end else begin
            if (popped) void'(exp_q.pop_front());
            if (!m_out) m_out = enable && (exp_q.size() < DEPTH);
        end
    endtask

    task automatic drive_mem();
        complete_instr = 1'b0;
        instr_dout     = 16'($urandom);
        if (instrmem_rd) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_left   = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
            end
            mem_left--;
            if (mem_left == 0) begin
                complete_instr = 1'b1;
                instr_dout     = mem_word(pc);
                mem_active     = 1'b0;
                n_cpl++;
            end
        end else begin
            mem_active = 1'b0;
        end
    endtask

    task automatic tick();
        if (model_on) model_update();
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic step(input logic en, input logic rdy, input logic rv, input logic [15:0] rp);
        enable         = en;
        ibuf_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        drive_mem();
        tick();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        enable         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ibuf_ready     = 1'b0;
        complete_instr = 1'b0;
        mem_active     = 1'b0;
        repeat (2) @(negedge clock);
        exp_q.delete();
        m_out     = 1'b0;
        m_discard = 1'b0;
        m_pc      = 16'h3000;
        m_target  = '0;
        reset     = 1'b0;
        compare();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit          hit;
        logic        r_en, r_rdy, r_rv;
        logic [15:0] r_pc;

        // Reset values while reset is held.
        repeat (2) @(negedge clock);
        chk("reset_pc", pc, 16'h3000);
        chk("reset_rd", instrmem_rd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ibuf_valid", ibuf_valid, 0);
        chk("reset_ibuf_instr", ibuf_instr, 16'h0000);
        chk("reset_ibuf_pc", ibuf_pc, 16'h0000);

        // 1-cycle memory, decode always ready: back-to-back fetch from 0x3000.
        lat_fixed = 1;
        do_reset();
        step(1, 1, 0, 0);
        chk("a_rd_rise", instrmem_rd, 1);
        chk("a_first_pc", pc, 16'h3000);
        n_cpl = 0;
        step(1, 1, 0, 0);
        chk("a_head_pc", ibuf_pc, 16'h3000);
        chk("a_head_instr", ibuf_instr, 16'h4000);
        repeat (6) step(1, 1, 0, 0);
        chk("a_back_to_back", n_cpl, 7);
        chk("a_pc_after", pc, 16'h3007);

        // Decode stalled: buffer fills after two completions, then fetch stops.
        do_reset();
        n_cpl = 0;
        repeat (8) step(1, 0, 0, 0);
        chk("b_completions", n_cpl, 2);
        chk("b_rd_low", instrmem_rd, 0);
        chk("b_busy_low", busy, 0);
        chk("b_pc_next", pc, 16'h3002);
        step(1, 1, 0, 0);
        chk("b_resume_rd", instrmem_rd, 1);
        chk("b_resume_pc", pc, 16'h3002);

        // Redirect while a 5-cycle fetch of 0x3001 is outstanding.
        do_reset();
        lat_fixed = 5;
        repeat (6) step(1, 0, 0, 0);
        chk("c_pending_pc", pc, 16'h3001);
        step(1, 0, 1, 16'h4000);
        chk("c_hold_pc", pc, 16'h3001);
        chk("c_hold_rd", instrmem_rd, 1);
        chk("c_flushed", ibuf_valid, 0);
        for (int i = 0; i < 20 && instrmem_rd; i++) step(1, 0, 0, 0);
        chk("c_drain_done", instrmem_rd, 0);
        chk("c_new_pc", pc, 16'h4000);
        chk("c_still_empty", ibuf_valid, 0);
        lat_fixed = 1;
        step(1, 0, 0, 0);
        chk("c_new_req_rd", instrmem_rd, 1);
        chk("c_new_req_pc", pc, 16'h4000);
        step(1, 0, 0, 0);
        chk("c_first_pc", ibuf_pc, 16'h4000);
        chk("c_first_instr", ibuf_instr, 16'h5000);

        // Redirect on the same cycle as the completion.
        do_reset();
        lat_fixed = 3;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            enable         = 1'b1;
            ibuf_ready     = 1'b1;
            redirect_valid = 1'b0;
            redirect_pc    = 16'h5000;
            drive_mem();
            if (complete_instr) begin
                redirect_valid = 1'b1;
                hit = 1'b1;
            end
            tick();
        end
        chk("d_coincident_seen", hit, 1);
        chk("d_rd_low", instrmem_rd, 0);
        chk("d_pc", pc, 16'h5000);
        chk("d_nothing_pushed", ibuf_valid, 0);
        step(1, 1, 0, 0);
        chk("d_next_rd", instrmem_rd, 1);
        chk("d_next_pc", pc, 16'h5000);

        // Address wrap at 0xFFFF.
        do_reset();
        lat_fixed = 1;
        step(0, 1, 0, 0);
        step(1, 1, 1, 16'hFFFF);
        chk("e_idle_redirect_pc", pc, 16'hFFFF);
        chk("e_idle_redirect_rd", instrmem_rd, 0);
        step(1, 1, 0, 0);
        chk("e_req_pc", pc, 16'hFFFF);
        step(1, 1, 0, 0);
        chk("e_wrap_pc", pc, 16'h0000);
        chk("e_wrap_rd", instrmem_rd, 1);
        chk("e_head_pc", ibuf_pc, 16'hFFFF);
        chk("e_head_instr", ibuf_instr, 16'h0FFF);
        repeat (3) step(1, 1, 0, 0);

        // Asynchronous reset in the middle of an outstanding request.
        do_reset();
        lat_fixed = 10;
        step(1, 1, 1, 16'h7777);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("f_async_rd", instrmem_rd, 0);
        chk("f_async_busy", busy, 0);
        chk("f_async_pc", pc, 16'h3000);
        @(negedge clock);
        mem_active = 1'b0;

        // Randomized traffic.
        lat_fixed = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r_en  = ($urandom_range(0, 9) != 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            step(r_en, r_rdy, r_rv, r_pc);
        end

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: watchdog fires 8 cycles into busy.
        model_on  = 1'b0;
        lat_fixed = 1000;
        do_reset();
        step(1, 1, 0, 0);
        chk("h_busy", busy, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        chk("h_not_yet", fetch_timeout, 0);
        chk("h_rd_held", instrmem_rd, 1);
        step(0, 1, 0, 0);
        chk("h_timeout", fetch_timeout, 1);
        chk("h_rd_low", instrmem_rd, 0);
        chk("h_busy_low", busy, 0);
        chk("h_pc_kept", pc, 16'h3000);
        complete_instr = 1'b1;
        instr_dout     = 16'hDEAD;
        @(posedge clock);
        @(negedge clock);
        complete_instr = 1'b0;
        chk("h_late_ignored", ibuf_valid, 0);
        chk("h_sticky", fetch_timeout, 1);
        lat_fixed  = 1;
        mem_active = 1'b0;
        step(1, 1, 0, 0);
        chk("h_retry_rd", instrmem_rd, 1);
        chk("h_retry_pc", pc, 16'h3000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
